// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: compares the newest len bits against a
// masked pattern, emits a registered match pulse and a saturating match count.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [MAX_LEN-1:0] cfg_mask,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               din_vld,
  input  logic               din,
  input  logic               clr_cnt,
  output logic               flag,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'((MAX_LEN < 4) ? MAX_LEN : 4);
  localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(4'b1101);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  logic [MAX_LEN-1:0] pat, mask, hist, nh;
  logic [LEN_W-1:0]   len, fill, nf;
  logic               ovl, match;

  assign nh = {hist[MAX_LEN-2:0], din};
  assign nf = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);

  // fill guards against matching on history bits older than the last reset/load
  always_comb begin
    match = din_vld && !cfg_we && (len != '0) && (nf >= len);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(len)) && mask[i] && (nh[i] != pat[i])) match = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat       <= PAT_RST;
      mask      <= '1;
      len       <= LEN_RST;
      ovl       <= 1'b1;
      hist      <= '0;
      fill      <= '0;
      flag      <= 1'b0;
      match_cnt <= '0;
    end else if (cfg_we) begin
      pat       <= cfg_pat;
      mask      <= cfg_mask;
      len       <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ovl       <= cfg_ovl;
      hist      <= '0;
      fill      <= '0;
      flag      <= 1'b0;
      match_cnt <= '0;
    end else begin
      flag <= match;
      if (din_vld) begin
        hist <= nh;
        fill <= (match && !ovl) ? '0 : nf;
      end
      if (clr_cnt)
        match_cnt <= '0;
      else if (match && (match_cnt != CNT_MAX))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog; a second instance with a 2-bit counter covers saturation.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [7:0] cfg_mask = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_ovl = 1'b0;
  logic       din_vld = 1'b0;
  logic       din = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       flag, flag2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .din_vld(din_vld), .din(din), .clr_cnt(clr_cnt),
    .flag(flag), .match_cnt(match_cnt));

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .din_vld(din_vld), .din(din), .clr_cnt(clr_cnt),
    .flag(flag2), .match_cnt(cnt2));

  typedef struct {
    logic       we;
    logic [7:0] pat;
    logic [7:0] mask;
    logic [3:0] len;
    logic       ovl;
    logic       vld;
    logic       din;
    logic       clr;
    logic       eflag;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // din_vld=1 during a load must be ignored
  function automatic void v_cfg(input logic [7:0] p, input logic [7:0] m,
                                input logic [3:0] l, input logic o);
    vec_t v = '{we:1'b1, pat:p, mask:m, len:l, ovl:o, vld:1'b1, din:1'b1, clr:1'b0,
                eflag:1'b0, ecnt:8'd0};
    vecs.push_back(v);
  endfunction

  // config inputs carry junk while cfg_we=0; they must have no effect
  function automatic void v_bit(input logic d, input logic ef, input logic [7:0] ec,
                                input logic c = 1'b0);
    vec_t v = '{we:1'b0, pat:8'h3C, mask:8'h00, len:4'd0, ovl:1'b0, vld:1'b1, din:d, clr:c,
                eflag:ef, ecnt:ec};
    vecs.push_back(v);
  endfunction

  function automatic void v_gap(input logic [7:0] ec);
    vec_t v = '{we:1'b0, pat:8'h00, mask:8'h00, len:4'd0, ovl:1'b0, vld:1'b0, din:1'b1,
                clr:1'b0, eflag:1'b0, ecnt:ec};
    vecs.push_back(v);
  endfunction

  task automatic step(input logic v, input logic d);
    cfg_we = 1'b0; din_vld = v; din = d; clr_cnt = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [7:0] m, input logic [3:0] l,
                        input logic o);
    cfg_we = 1'b1; cfg_pat = p; cfg_mask = m; cfg_len = l; cfg_ovl = o;
    din_vld = 1'b1; din = 1'b1; clr_cnt = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  function automatic logic [7:0] sat2(input logic [7:0] c);
    return (c > 8'd3) ? 8'd3 : c;
  endfunction

  initial begin
    // default overlapping 1101: 1,1,0,1,1,0,1
    v_bit(1, 0, 0); v_bit(1, 0, 0); v_bit(0, 0, 0); v_bit(1, 1, 1);
    v_bit(1, 0, 1); v_bit(0, 0, 1); v_bit(1, 1, 2);
    // non-overlapping 1101, then 1,1,0,1
    v_cfg(8'b1101, 8'hFF, 4'd4, 1'b0);
    v_bit(1, 0, 0); v_bit(1, 0, 0); v_bit(0, 0, 0); v_bit(1, 1, 1);
    v_bit(1, 0, 1); v_bit(0, 0, 1); v_bit(1, 0, 1);
    v_bit(1, 0, 1); v_bit(1, 0, 1); v_bit(0, 0, 1); v_bit(1, 1, 2);
    // masked 1xx1, non-overlapping
    v_cfg(8'b1001, 8'b1001, 4'd4, 1'b0);
    v_bit(1, 0, 0); v_bit(1, 0, 0); v_bit(1, 0, 0); v_bit(1, 1, 1);
    v_bit(1, 0, 1); v_bit(0, 0, 1); v_bit(0, 0, 1); v_bit(1, 1, 2);
    // len 0 with everything don't-care never matches
    v_cfg(8'h00, 8'h00, 4'd0, 1'b1);
    v_bit(1, 0, 0); v_bit(0, 0, 0); v_bit(1, 0, 0); v_bit(1, 0, 0); v_bit(0, 0, 0);
    // len 11 clamps to 8: low-nibble hits before 8 samples must not count
    v_cfg(8'h05, 8'h0F, 4'd11, 1'b1);
    v_bit(0, 0, 0); v_bit(1, 0, 0); v_bit(0, 0, 0); v_bit(1, 0, 0);
    v_bit(0, 0, 0); v_bit(1, 0, 0); v_bit(0, 0, 0); v_bit(1, 1, 1);
    v_bit(0, 0, 1); v_bit(1, 1, 2);
    // single-bit pattern: consecutive pulses, saturation, clr_cnt priority
    v_cfg(8'h01, 8'hFF, 4'd1, 1'b1);
    v_bit(1, 1, 1); v_bit(1, 1, 2); v_bit(1, 1, 3);
    v_bit(1, 1, 4); v_bit(1, 1, 5); v_bit(1, 1, 6);
    v_bit(1, 1, 0, 1'b1);
    v_gap(0);
    v_bit(0, 0, 0); v_bit(1, 1, 1);

    // reset state, asserted asynchronously from time 0
    #12;
    chk("rst flag", flag, 1'b0);
    chk("rst cnt", match_cnt, 8'd0);
    chk("rst cnt2", cnt2, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      cfg_we = vecs[k].we; cfg_pat = vecs[k].pat; cfg_mask = vecs[k].mask;
      cfg_len = vecs[k].len; cfg_ovl = vecs[k].ovl; din_vld = vecs[k].vld;
      din = vecs[k].din; clr_cnt = vecs[k].clr;
      @(posedge clk); #1;
      chk($sformatf("v%0d flag", k), flag, vecs[k].eflag);
      chk($sformatf("v%0d cnt", k), match_cnt, vecs[k].ecnt);
      chk($sformatf("v%0d cnt2", k), cnt2, sat2(vecs[k].ecnt));
    end

    // cfg_we after a partial 0,1,1 discards it
    do_cfg(8'b0110, 8'hFF, 4'd4, 1'b1);
    step(1, 0); step(1, 1); step(1, 1);
    do_cfg(8'b0110, 8'hFF, 4'd4, 1'b1);
    chk("cfgmid load flag", flag, 1'b0);
    step(1, 0);
    chk("cfgmid flag", flag, 1'b0);
    chk("cfgmid cnt", match_cnt, 8'd0);
    step(1, 1); step(1, 1); step(1, 0);
    chk("cfgmid fresh flag", flag, 1'b1);
    chk("cfgmid fresh cnt", match_cnt, 8'd1);

    // asynchronous reset takes effect between edges
    #2 rst_n = 1'b0;
    #1;
    chk("async flag", flag, 1'b0);
    chk("async cnt", match_cnt, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 1); step(1, 1); step(1, 0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(1, 1);
    chk("rstmid flag", flag, 1'b0);
    step(1, 1); step(1, 0); step(1, 1);
    chk("rstmid dflt flag", flag, 1'b1);
    chk("rstmid dflt cnt", match_cnt, 8'd1);

    // din_vld gaps inside 1,1,0,1
    step(1, 1);
    chk("gap b1", flag, 1'b0);
    step(0, 0);
    chk("gap g1", flag, 1'b0);
    step(1, 1);
    chk("gap b2", flag, 1'b0);
    step(0, 1); step(0, 0);
    step(1, 0);
    chk("gap b3", flag, 1'b0);
    step(0, 1);
    chk("gap g3", flag, 1'b0);
    step(1, 1);
    chk("gap b4 flag", flag, 1'b1);
    chk("gap b4 cnt", match_cnt, 8'd2);
    step(0, 1);
    chk("gap after flag", flag, 1'b0);
    chk("gap after cnt", match_cnt, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
